// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: definitions shared by the memory arbiter, the cache
// controllers and the data memory model.
//   - arb_state_e : arbiter state encoding (IDLE / BUSY0 / BUSY1)
//   - ADDR_W_DEF  : default line address width
//   - LINE_W_DEF  : default cache line / memory data width
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY0 = 2'd1,
        ARB_BUSY1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts the cycles a memory transaction has been waiting
// for its acknowledge and raises a sticky error once TIMEOUT is reached.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-low reset
//   busy_i       : a transaction is in progress this cycle
//   ack_i        : memory acknowledged this cycle (no count)
//   clear_i      : restart the count (held while the arbiter is idle)
//   err_o        : sticky timeout flag, cleared only by reset
module mem_arb_watchdog #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic ack_i,
    input  logic clear_i,
    output logic err_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // The count stops at TIMEOUT; reaching it sets the error and the
    // transaction is left waiting rather than being killed.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (busy_i && !ack_i) begin
            if (cnt_q == CNT_W'(TIMEOUT)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single line-wide data memory port between the
// instruction cache (port 0) and the data cache (port 1). One transaction at
// a time; the grant is held until the memory acknowledges, followed by one
// idle turnaround cycle.
// Build option: MEM_ARBITER_RR_EN -- when defined, a tie in IDLE goes to the
// port that was not granted last (round-robin); when undefined, port 1
// always wins ties.
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   pX_enable_i/write_i    : port X request (held until pX_ack_o) and direction
//   pX_addr_i/data_i       : port X line address and write data
//   pX_ack_o               : port X transaction done (1-cycle pulse)
//   rd_data_o              : read data broadcast to both ports
//   mem_enable_o/write_o   : memory request and direction
//   mem_addr_o/data_o      : memory address and write data
//   mem_data_i, mem_ack_i  : memory read data and 1-cycle acknowledge
//   err_o                  : sticky watchdog error
//
// Handshake: a port raises enable with stable write/addr/data and keeps them
// stable until it sees its ack; the ack cycle completes the transfer. A port
// dropping enable before its ack aborts the transfer, and a late memory ack
// is then ignored.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [LINE_W-1:0] rd_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    arb_state_e state_q;
    logic       last_grant_q;
    arb_state_e tie_state;

`ifdef MEM_ARBITER_RR_EN
    assign tie_state = last_grant_q ? ARB_BUSY0 : ARB_BUSY1;
`else
    // last_grant is still tracked so the round-robin build is a drop-in.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
    assign tie_state         = ARB_BUSY1;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (p0_enable_i && p1_enable_i) state_q <= tie_state;
                    else if (p1_enable_i)           state_q <= ARB_BUSY1;
                    else if (p0_enable_i)           state_q <= ARB_BUSY0;
                end
                ARB_BUSY0: begin
                    if (mem_ack_i) begin
                        state_q      <= ARB_IDLE;
                        last_grant_q <= 1'b0;
                    end else if (!p0_enable_i) begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_BUSY1: begin
                    if (mem_ack_i) begin
                        state_q      <= ARB_IDLE;
                        last_grant_q <= 1'b1;
                    end else if (!p1_enable_i) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Memory side follows the granted port directly so the request is seen
    // in the first BUSY cycle; everything is zero while idle.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            ARB_BUSY0: begin
                mem_enable_o = 1'b1;
                mem_write_o  = p0_write_i;
                mem_addr_o   = p0_addr_i;
                mem_data_o   = p0_data_i;
            end
            ARB_BUSY1: begin
                mem_enable_o = 1'b1;
                mem_write_o  = p1_write_i;
                mem_addr_o   = p1_addr_i;
                mem_data_o   = p1_data_i;
            end
            default: ;
        endcase
    end

    assign p0_ack_o  = mem_ack_i && (state_q == ARB_BUSY0);
    assign p1_ack_o  = mem_ack_i && (state_q == ARB_BUSY1);
    assign rd_data_o = mem_data_i;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .busy_i  (state_q != ARB_IDLE),
        .ack_i   (mem_ack_i),
        .clear_i (state_q == ARB_IDLE),
        .err_o   (err_o)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 15;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
  logic [ADDR_W-1:0] p0_addr_i, p1_addr_i;
  logic [LINE_W-1:0] p0_data_i, p1_data_i;
  logic              p0_ack_o, p1_ack_o;
  logic [LINE_W-1:0] rd_data_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic              err_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ADDR_W-1:0] exp_q[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT), .CNT_W(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o),
    .rd_data_o(rd_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_inputs();
    p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    p0_enable_i = 1'b1;
    p0_addr_i   = 32'h1234_5640;
    mem_data_i  = rand_line();
    rst_i = 1'b0;
    tick();
    tick();
    #1;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL reset_mem_enable: got %0b want 0", mem_enable_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err_o); end
    n_cmp++; if (mem_addr_o !== '0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
    n_cmp++; if (rd_data_o !== mem_data_i) begin n_bad++; $display("FAIL reset_rd_data: got %h want %h", rd_data_o, mem_data_i); end
    rst_i = 1'b1;
    #1;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL release_before_edge: got %0b want 0", mem_enable_o); end
    tick();
    n_cmp++; if (mem_enable_o !== 1'b1) begin n_bad++; $display("FAIL release_grant_en: got %0b want 1", mem_enable_o); end
    n_cmp++; if (mem_addr_o !== p0_addr_i) begin n_bad++; $display("FAIL release_grant_addr: got %h want %h", mem_addr_o, p0_addr_i); end
    mem_ack_i = 1'b1;
    #1;
    n_cmp++; if (p0_ack_o !== 1'b1) begin n_bad++; $display("FAIL release_p0_ack: got %0b want 1", p0_ack_o); end
    tick();
    mem_ack_i = 1'b0;
    p0_enable_i = 1'b0;
    #1;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL release_after_ack_en: got %0b want 0", mem_enable_o); end
    tick();
  endtask

  task automatic test_p1_write();
    logic [LINE_W-1:0] aa;
    int acks;
    aa = {32{8'hAA}};
    acks = 0;
    do_reset();
    p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h400; p1_data_i = aa;
    tick();
    for (int c = 1; c <= 10; c++) begin
      mem_ack_i = (c == 10);
      #1;
      n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1) begin n_bad++; $display("FAIL p1w_en_wr c=%0d: got en=%0b wr=%0b want 1 1", c, mem_enable_o, mem_write_o); end
      n_cmp++; if (mem_data_o !== aa || mem_addr_o !== 32'h400) begin n_bad++; $display("FAIL p1w_data_addr c=%0d: got addr=%h data=%h", c, mem_addr_o, mem_data_o); end
      n_cmp++; if (p0_ack_o !== 1'b0) begin n_bad++; $display("FAIL p1w_p0_ack c=%0d: got %0b want 0", c, p0_ack_o); end
      if (p1_ack_o === 1'b1) acks++;
      tick();
    end
    mem_ack_i = 1'b0;
    p1_enable_i = 1'b0;
    #1;
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL p1w_ack_count: got %0d want 1", acks); end
    n_cmp++; if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin n_bad++; $display("FAIL p1w_idle: got en=%0b wr=%0b want 0 0", mem_enable_o, mem_write_o); end
    tick();
  endtask

  task automatic test_tie();
    logic [ADDR_W-1:0] addr [2];
    logic [LINE_W-1:0] line;
    int first, port;
    addr[0] = 32'h0;
    addr[1] = 32'h20;
    do_reset();
`ifdef MEM_ARBITER_RR_EN
    first = 0;
`else
    first = 1;
`endif
    p0_addr_i = addr[0]; p1_addr_i = addr[1];
    p0_enable_i = 1'b1; p1_enable_i = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      port = (k == 0) ? first : 1 - first;
      for (int c = 1; c <= 3; c++) begin
        line = rand_line();
        mem_data_i = line;
        mem_ack_i = (c == 3);
        #1;
        n_cmp++; if (mem_enable_o !== 1'b1 || mem_addr_o !== addr[port] || mem_write_o !== 1'b0) begin n_bad++; $display("FAIL tie_grant k=%0d c=%0d: got en=%0b addr=%h want addr=%h", k, c, mem_enable_o, mem_addr_o, addr[port]); end
        if (c == 3) begin
          n_cmp++; if (p0_ack_o !== (port == 0) || p1_ack_o !== (port == 1)) begin n_bad++; $display("FAIL tie_ack k=%0d: got p0=%0b p1=%0b want port %0d", k, p0_ack_o, p1_ack_o, port); end
          n_cmp++; if (rd_data_o !== line) begin n_bad++; $display("FAIL tie_rd_data k=%0d: got %h want %h", k, rd_data_o, line); end
        end
        tick();
      end
      mem_ack_i = 1'b0;
      if (port == 0) p0_enable_i = 1'b0; else p1_enable_i = 1'b0;
      #1;
      n_cmp++; if (mem_enable_o !== 1'b0 || p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0) begin n_bad++; $display("FAIL tie_turnaround k=%0d: got en=%0b want 0", k, mem_enable_o); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int order [3];
`ifdef MEM_ARBITER_RR_EN
    order[0] = 0; order[1] = 1; order[2] = 0;
`else
    order[0] = 1; order[1] = 1; order[2] = 1;
`endif
    do_reset();
    p0_addr_i = 32'h100; p1_addr_i = 32'h200;
    for (int t = 0; t < 3; t++) exp_q.push_back(order[t] == 0 ? 32'h100 : 32'h200);
    p0_enable_i = 1'b1; p1_enable_i = 1'b1;
    tick();
    for (int t = 0; t < 3; t++) begin
      mem_ack_i = 1'b1;
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_queue t=%0d: expected queue empty", t); end
      else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        if (mem_enable_o !== 1'b1 || mem_addr_o !== e) begin n_bad++; $display("FAIL b2b_grant t=%0d: got en=%0b addr=%h want addr=%h", t, mem_enable_o, mem_addr_o, e); end
      end
      tick();
      mem_ack_i = 1'b0;
      #1;
      n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL b2b_turnaround t=%0d: got %0b want 0", t, mem_enable_o); end
      tick();
    end
    p0_enable_i = 1'b0; p1_enable_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    p1_enable_i = 1'b1; p1_addr_i = 32'h80;
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c == 3) p1_enable_i = 1'b0;
      mem_ack_i = (c == 5);
      #1;
      n_cmp++; if (mem_enable_o !== (c <= 3)) begin n_bad++; $display("FAIL abort_en c=%0d: got %0b want %0b", c, mem_enable_o, (c <= 3)); end
      n_cmp++; if (p1_ack_o !== 1'b0 || p0_ack_o !== 1'b0) begin n_bad++; $display("FAIL abort_ack c=%0d: got p0=%0b p1=%0b want 0 0", c, p0_ack_o, p1_ack_o); end
      tick();
    end
    mem_ack_i = 1'b0;
  endtask

  task automatic test_random();
    int owner, m_last, wait_c, lat, done;
    logic pend [2];
    logic [ADDR_W-1:0] ra [2];
    logic [LINE_W-1:0] rdat [2];
    logic rw [2];
    logic ack;
    do_reset();
    owner = -1; m_last = 1; wait_c = 0; lat = 1; done = 0;
    for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; ra[p] = '0; rdat[p] = '0; rw[p] = 1'b0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          ra[p]   = $urandom & 32'hFFFF_FFE0;
          rw[p]   = 1'($urandom_range(0, 1));
          rdat[p] = rand_line();
        end
      end
      p0_enable_i = pend[0]; p0_write_i = rw[0]; p0_addr_i = ra[0]; p0_data_i = rdat[0];
      p1_enable_i = pend[1]; p1_write_i = rw[1]; p1_addr_i = ra[1]; p1_data_i = rdat[1];
      ack = (owner != -1) && (wait_c >= lat);
      mem_ack_i = ack;
      mem_data_i = rand_line();
      #1;
      n_cmp++; if (mem_enable_o !== (owner != -1)) begin n_bad++; $display("FAIL rnd_en cyc=%0d: got %0b want %0b", cyc, mem_enable_o, (owner != -1)); end
      if (owner != -1) begin
        n_cmp++; if (mem_addr_o !== ra[owner] || mem_write_o !== rw[owner] || mem_data_o !== rdat[owner]) begin n_bad++; $display("FAIL rnd_mux cyc=%0d: got addr=%h wr=%0b want addr=%h wr=%0b", cyc, mem_addr_o, mem_write_o, ra[owner], rw[owner]); end
      end else begin
        n_cmp++; if (mem_addr_o !== '0 || mem_write_o !== 1'b0 || mem_data_o !== '0) begin n_bad++; $display("FAIL rnd_idle_out cyc=%0d: got addr=%h wr=%0b want 0", cyc, mem_addr_o, mem_write_o); end
      end
      n_cmp++; if (p0_ack_o !== (ack && owner == 0) || p1_ack_o !== (ack && owner == 1)) begin n_bad++; $display("FAIL rnd_ack cyc=%0d: got p0=%0b p1=%0b owner=%0d ack=%0b", cyc, p0_ack_o, p1_ack_o, owner, ack); end
      n_cmp++; if (rd_data_o !== mem_data_i || err_o !== 1'b0) begin n_bad++; $display("FAIL rnd_rd_err cyc=%0d: err=%0b rd_data match=%0b", cyc, err_o, rd_data_o === mem_data_i); end
      if (p0_ack_o === 1'b1 || p1_ack_o === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL rnd_sb cyc=%0d: ack with empty expected queue", cyc); end
        else begin
          logic [ADDR_W-1:0] e;
          e = exp_q.pop_front();
          if (mem_addr_o !== e) begin n_bad++; $display("FAIL rnd_sb cyc=%0d: got addr=%h want %h", cyc, mem_addr_o, e); end
        end
      end
      // reference model: one owner at a time, idle cycle after each ack
      if (owner == -1) begin
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARBITER_RR_EN
          owner = (m_last == 1) ? 0 : 1;
`else
          owner = 1;
`endif
        end else if (pend[1]) owner = 1;
        else if (pend[0]) owner = 0;
        if (owner != -1) begin
          wait_c = 1;
          lat = $urandom_range(1, 6);
          exp_q.push_back(ra[owner]);
        end
      end else if (ack) begin
        pend[owner] = 1'b0;
        m_last = owner;
        owner = -1;
        done++;
      end else begin
        wait_c++;
      end
      tick();
    end
    // drain whatever transaction is still open
    for (int c = 0; c < 10 && owner != -1; c++) begin
      mem_ack_i = 1'b1;
      #1;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
      owner = -1;
    end
    clear_inputs();
    tick();
    exp_q.delete();
    n_cmp++; if (done < 20) begin n_bad++; $display("FAIL rnd_progress: got %0d transactions want >= 20", done); end
  endtask

  task automatic test_watchdog();
    do_reset();
    p0_enable_i = 1'b1; p0_addr_i = 32'h40;
    tick();
    for (int c = 1; c <= 24; c++) begin
      mem_ack_i = (c == 24);
      #1;
      n_cmp++; if (err_o !== (c >= 17)) begin n_bad++; $display("FAIL wd_err c=%0d: got %0b want %0b", c, err_o, (c >= 17)); end
      n_cmp++; if (mem_enable_o !== 1'b1) begin n_bad++; $display("FAIL wd_en c=%0d: got %0b want 1", c, mem_enable_o); end
      if (c == 24) begin
        n_cmp++; if (p0_ack_o !== 1'b1) begin n_bad++; $display("FAIL wd_late_ack: got %0b want 1", p0_ack_o); end
      end
      tick();
    end
    mem_ack_i = 1'b0;
    p0_enable_i = 1'b0;
    #1;
    n_cmp++; if (err_o !== 1'b1 || mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL wd_sticky: got err=%0b en=%0b want 1 0", err_o, mem_enable_o); end
    tick();
    do_reset();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL wd_reset_clear: got %0b want 0", err_o); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    rst_i = 1'b0;
    test_reset();
    test_p1_write();
    test_tie();
    test_back_to_back();
    test_abort();
    test_random();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single 256-bit data memory port between the instruction cache (port 0) and the data cache (port 1).
- Sits between both cache controllers and the data memory.
- Serialises line fills and write-backs: one transaction at a time, grant held until the memory acks.
- Watchdog counter flags a memory that never acknowledges.

Parameters:
- ADDR_W, 32, address width
- LINE_W, 256, cache line / memory data width
- TIMEOUT, 1023, max cycles in a BUSY state before err_o sets; must be < 2^CNT_W
- CNT_W, 10, watchdog counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- p0_enable_i  in  1  port 0 request, held high until p0_ack_o
- p0_write_i  in  1  port 0 write (1) / read (0)
- p0_addr_i  in  ADDR_W  port 0 line address
- p0_data_i  in  LINE_W  port 0 write data
- p0_ack_o  out  1  port 0 transaction done
- p1_enable_i  in  1  port 1 request
- p1_write_i  in  1  port 1 write/read
- p1_addr_i  in  ADDR_W  port 1 line address
- p1_data_i  in  LINE_W  port 1 write data
- p1_ack_o  out  1  port 1 transaction done
- rd_data_o  out  LINE_W  read data, broadcast to both ports (= mem_data_i)
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  LINE_W  memory write data
- mem_data_i  in  LINE_W  memory read data
- mem_ack_i  in  1  memory acknowledge, 1-cycle pulse
- err_o  out  1  sticky watchdog error

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registered state plus last_grant bit and watchdog counter cnt.
- Reset (async, rst_i low):
  - state=IDLE, last_grant=1, cnt=0, err_o=0.
  - All outputs 0 except rd_data_o, which follows mem_data_i.
- IDLE:
  - Only p0_enable_i high -> BUSY0.
  - Only p1_enable_i high -> BUSY1.
  - Both high -> BUSY1 (fixed priority: data cache wins).
  - Neither -> IDLE.
  - Grant decision is registered: 1-cycle arbitration latency from request to mem_enable_o.
- BUSYx:
  - mem_enable_o=1.
  - mem_write_o, mem_addr_o, mem_data_o = the granted port's inputs, muxed combinationally from state.
  - Granted port's inputs must stay stable until its ack.
  - Non-granted port sees ack 0 and simply waits with enable held.
- Ack routing:
  - px_ack_o = mem_ack_i & (state==BUSYx), combinational.
  - mem_ack_i in IDLE is ignored.
- mem_ack_i in BUSYx -> IDLE; last_grant<=x.
  - Always one IDLE turnaround cycle between transactions, so mem_enable_o drops for at least one cycle after every ack.
- Abort:
  - Granted port drops enable before ack -> IDLE next cycle; mem_enable_o deasserts that cycle.
  - Any later mem_ack_i is ignored.
- Watchdog:
  - cnt clears on entering BUSYx and increments each BUSY cycle without ack.
  - cnt==TIMEOUT -> err_o<=1 (sticky until reset), cnt saturates.
  - State is unchanged; the transaction continues waiting.
- Outputs in IDLE: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
- Reset mid-transaction: immediate return to IDLE with outputs 0; memory must tolerate enable dropping.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: tie in IDLE (both ports requesting) goes to the port != last_grant (round-robin).
- Undefined: fixed priority, port 1 always wins ties; last_grant is kept but unused for decisions.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding constants ARB_IDLE=2'd0, ARB_BUSY0=2'd1, ARB_BUSY1=2'd2
  - LINE_W/ADDR_W defaults, shared with the cache and memory blocks
- One natural sub-module: mem_arb_watchdog (counter + sticky err, inputs busy/ack/clear).
- The rest stays flat.

Test Plan:
- Reset: hold rst_i low with p0_enable_i=1 -> mem_enable_o=0, err_o=0. Release -> mem_enable_o=1 one cycle after the first clock edge, mem_addr_o=p0_addr_i.
- Single p1 write: addr 0x400, data 0xAA..AA, memory acks after 10 cycles -> mem_write_o=1 and mem_data_o=0xAA..AA for 10 cycles; p1_ack_o pulses once, p0_ack_o stays 0.
- Simultaneous p0 read 0x0 and p1 read 0x20 (fixed priority) -> p1 served first. After its ack there is 1 IDLE cycle, then p0 is served. rd_data_o carries each line.
- With MEM_ARBITER_RR_EN, three back-to-back ties -> grant order 0,1,0 after reset (last_grant=1).
- Abort: p1 granted, drop p1_enable_i at cycle 3, then mem_ack_i arrives at cycle 5 -> mem_enable_o low from cycle 4; no p1_ack_o at cycle 5.
- Watchdog: TIMEOUT=15, memory never acks -> err_o rises 16 cycles after BUSY entry and stays high; a later ack completes normally with err_o still 1.
